// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART program loader.
package loader_pkg;

    // Receiver states: wait for a start edge, confirm it at mid-bit,
    // shift in eight data bits, then check the stop bit.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Two bytes form one 16-bit instruction word.
    localparam int BYTES_PER_WORD = 2;

    // Clock cycles per serial bit, truncated.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchronizer, mid-bit sampling timer, RX FSM and shift register.
module uart_byte_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_frame_err_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic            sync1_q, sync2_q;
    rx_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
        end
    end

    // Receiver state, bit timer and shift register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state logic; the timer counts down to zero and samples on expiry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_M1;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (!sync2_q) begin
                        state_d   = RX_DATA;
                        cnt_d     = FULL_M1;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line already high again at mid start bit: a glitch.
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    // Leave at mid stop bit so a back-to-back start edge is caught.
                    if (sync2_q) begin
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_valid_o     = valid_q;
    assign rx_byte_o      = shift_q;
    assign rx_frame_err_o = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Receives a program over UART and writes it word by word into instruction memory.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int PROG_DEPTH = 32,
    parameter int ADDR_W     = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              UART_TXD_IN,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              load_done,
    output logic              frame_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int WORD_W       = 8 * BYTES_PER_WORD;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              rx_frame_err;

    logic              hi_pending_q, hi_pending_d;
    logic [7:0]        hi_byte_q, hi_byte_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              load_done_q, load_done_d;
    logic              frame_err_q, frame_err_d;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i         (CLK),
        .rst_i         (RST),
        .rxd_i         (UART_TXD_IN),
        .rx_valid_o    (rx_valid),
        .rx_byte_o     (rx_byte),
        .rx_frame_err_o(rx_frame_err)
    );

    // Word assembler, write port and status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hi_pending_q <= 1'b0;
            hi_byte_q    <= '0;
            word_cnt_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            load_done_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            hi_pending_q <= hi_pending_d;
            hi_byte_q    <= hi_byte_d;
            word_cnt_q   <= word_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            load_done_q  <= load_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Pair bytes high-first; once the program is complete, bytes are ignored.
    always_comb begin
        hi_pending_d = hi_pending_q;
        hi_byte_d    = hi_byte_q;
        word_cnt_d   = word_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        if (rx_valid && !load_done_q) begin
            if (!hi_pending_q) begin
                hi_byte_d    = rx_byte;
                hi_pending_d = 1'b1;
            end else begin
                wr_en_d      = 1'b1;
                wr_addr_d    = word_cnt_q;
                wr_data_d    = {hi_byte_q, rx_byte};
                hi_pending_d = 1'b0;
                // Hold at the last address rather than wrapping.
                if (word_cnt_q != LAST_ADDR) begin
                    word_cnt_d = word_cnt_q + ADDR_ONE;
                end
            end
        end
        load_done_d = load_done_q | (wr_en_q && (wr_addr_q == LAST_ADDR));
        frame_err_d = frame_err_q | rx_frame_err;
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign load_done = load_done_q;
    assign frame_err = frame_err_q;

endmodule
